// File: rtl/spi_read_pkg.sv
// Shared SPI definitions: FSM state encodings, NDATA default and datapath widths.
package spi_read_pkg;

    localparam int unsigned NDATA_DEFAULT = 48;
    localparam int unsigned RDATA_W       = 64;
    localparam int unsigned CNT_W         = 7;
    localparam int unsigned IDX_W         = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/spi_edge_detect.sv
// Rising-edge detector on a synchronous level input; shared by the SPI read and write paths.
module spi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= in;
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/spi_read.sv
// SPI chain read-back: strobes sload, clocks NDATA bits out of the chip chain into rdata.
// SPI_READ_MSB_FIRST_EN defined: the first received bit lands in rdata[NDATA-1] instead of rdata[0].
module spi_read
    import spi_read_pkg::*;
#(
    parameter int unsigned NDATA = NDATA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sdin,
    output logic               swr,
    output logic               sclk,
    output logic               sload,
    output logic               sreset,
    output logic [RDATA_W-1:0] rdata,
    output logic               done
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               sclk_d, sload_d, done_d;
    logic [RDATA_W-1:0] rdata_d;
    logic [IDX_W-1:0]   bit_idx;
    logic               en_rise;

    spi_edge_detect u_en_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (en),
        .rise (en_rise)
    );

    assign swr = 1'b0;

`ifdef SPI_READ_MSB_FIRST_EN
    assign bit_idx = IDX_W'(CNT_W'(NDATA - 1) - cnt);
`else
    assign bit_idx = IDX_W'(cnt);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sclk   <= 1'b0;
            sload  <= 1'b0;
            sreset <= 1'b1;
            done   <= 1'b0;
            rdata  <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            sclk   <= sclk_d;
            sload  <= sload_d;
            sreset <= 1'b0;
            done   <= done_d;
            rdata  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sclk_d  = sclk;
        sload_d = sload;
        done_d  = done;
        rdata_d = rdata;

        case (state)
            IDLE: begin
                sclk_d  = 1'b0;
                sload_d = 1'b0;
                if (en_rise) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    rdata_d = '0;
                    done_d  = 1'b0;
                end
            end

            // sload held across one sclk rise so the chip latches its parallel inputs
            CAPTURE: begin
                case (cnt)
                    CNT_W'(0): begin
                        sload_d = 1'b1;
                        sclk_d  = 1'b0;
                        cnt_d   = CNT_W'(1);
                    end
                    CNT_W'(1): begin
                        sload_d = 1'b1;
                        sclk_d  = 1'b1;
                        cnt_d   = CNT_W'(2);
                    end
                    default: begin
                        sload_d = 1'b0;
                        sclk_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                endcase
            end

            // sample while sclk is low, then raise sclk so the chip advances to the next bit
            SHIFT: begin
                if (!sclk) begin
                    rdata_d[bit_idx] = sdin;
                    sclk_d           = 1'b1;
                    cnt_d            = cnt + CNT_W'(1);
                end else begin
                    sclk_d = 1'b0;
                    if (cnt == CNT_W'(NDATA)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                sclk_d  = 1'b0;
                sload_d = 1'b0;
                if (!en) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_read.sv
// Directed bench for spi_read: default-width instance plus an NDATA=64 instance, each with a chip-chain model.
module tb_spi_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic        sdin_a, sdin_b;
    logic        swr_a, sclk_a, sload_a, sreset_a, done_a;
    logic        swr_b, sclk_b, sload_b, sreset_b, done_b;
    logic [63:0] rdata_a, rdata_b;
    logic [63:0] chip_a_data, chip_a_sr;
    logic [63:0] chip_b_data, chip_b_sr;

    int checks = 0;
    int errors = 0;

`ifdef SPI_READ_MSB_FIRST_EN
    localparam logic [63:0] EXP_P1 = 64'h0000_2C48_F0F0_A5A5;
    localparam logic [63:0] EXP_P2 = 64'h0000_8000_0000_0000;
    localparam logic [63:0] EXP_P3 = 64'h0000_3D59_1E6A_2C48;
`else
    localparam logic [63:0] EXP_P1 = 64'h0000_A5A5_0F0F_1234;
    localparam logic [63:0] EXP_P2 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] EXP_P3 = 64'h0000_1234_5678_9ABC;
`endif

    always #5 clk = ~clk;

    spi_read u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .sdin(sdin_a),
        .swr(swr_a), .sclk(sclk_a), .sload(sload_a), .sreset(sreset_a),
        .rdata(rdata_a), .done(done_a)
    );

    spi_read #(.NDATA(64)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .sdin(sdin_b),
        .swr(swr_b), .sclk(sclk_b), .sload(sload_b), .sreset(sreset_b),
        .rdata(rdata_b), .done(done_b)
    );

    // Chip chain: parallel load on sclk rise with sload, otherwise shift toward bit 0
    always @(posedge sclk_a or posedge rst) begin
        if (rst)          chip_a_sr <= '0;
        else if (sload_a) chip_a_sr <= chip_a_data;
        else              chip_a_sr <= chip_a_sr >> 1;
    end
    assign sdin_a = chip_a_sr[0];

    always @(posedge sclk_b or posedge rst) begin
        if (rst)          chip_b_sr <= '0;
        else if (sload_b) chip_b_sr <= chip_b_data;
        else              chip_b_sr <= chip_b_sr >> 1;
    end
    assign sdin_b = chip_b_sr[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raise en_a for roughly 'hold' cycles and run until done (bounded)
    task automatic txn_a(input int hold, output int n, output int sl, output int pl);
        logic ps;
        ps = 1'b0; n = 0; sl = 0; pl = 0;
        @(negedge clk); en_a = 1'b1;
        @(posedge clk); #1;
        if (hold <= 1) en_a = 1'b0;
        check("done_clear_on_start", 64'(done_a), 64'd0);
        while (done_a !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n + 1 >= hold) en_a = 1'b0;
            if (sload_a) sl++;
            if (sclk_a && !ps && !sload_a) pl++;
            ps = sclk_a;
        end
    endtask

    initial begin
        int n, sl, pl, extra_sload;

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        chip_a_data = '0; chip_b_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sreset", 64'(sreset_a), 64'd1);
        check("rst_sclk",   64'(sclk_a),   64'd0);
        check("rst_sload",  64'(sload_a),  64'd0);
        check("rst_done",   64'(done_a),   64'd0);
        check("rst_rdata",  rdata_a,       64'd0);
        check("rst_swr",    64'(swr_a),    64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("sreset_release", 64'(sreset_a), 64'd0);

        // Pattern 1, single-cycle en pulse
        chip_a_data = 64'h0000_A5A5_0F0F_1234;
        txn_a(1, n, sl, pl);
        check("p1_done_edge",   64'(n),  64'd99);
        check("p1_sload_cyc",   64'(sl), 64'd2);
        check("p1_sclk_pulses", 64'(pl), 64'd48);
        check("p1_rdata",       rdata_a, EXP_P1);
        @(posedge clk); #1;
        check("p1_done_idle",   64'(done_a), 64'd1);
        check("p1_sclk_idle",   64'(sclk_a), 64'd0);
        check("p1_swr",         64'(swr_a),  64'd0);

        // Pattern 2, single set bit: exposes bit ordering
        repeat (2) @(posedge clk);
        chip_a_data = 64'h0000_0000_0000_0001;
        txn_a(1, n, sl, pl);
        check("p2_done_edge", 64'(n), 64'd99);
        check("p2_rdata",     rdata_a, EXP_P2);

        // Pattern 3, en held high 200 cycles: exactly one transaction
        repeat (2) @(posedge clk);
        chip_a_data = 64'h0000_1234_5678_9ABC;
        txn_a(200, n, sl, pl);
        check("p3_done_edge", 64'(n),  64'd99);
        check("p3_rdata",     rdata_a, EXP_P3);
        extra_sload = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (sload_a) extra_sload++;
        end
        check("p3_no_retrigger",  64'(extra_sload), 64'd0);
        check("p3_done_held",     64'(done_a),      64'd1);
        check("p3_rdata_held",    rdata_a,          EXP_P3);
        @(negedge clk); en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("p3_done_after_en_low", 64'(done_a), 64'd1);

        // Reset mid-shift at cnt=20 (edge 42 after detection)
        chip_a_data = 64'h0000_FFFF_FFFF_FFFF;
        @(negedge clk); en_a = 1'b1;
        @(posedge clk); #1; en_a = 1'b0;
        repeat (42) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        check("abort_rdata_async", rdata_a, 64'd0);
        @(posedge clk); #1;
        check("abort_sclk",   64'(sclk_a),   64'd0);
        check("abort_sload",  64'(sload_a),  64'd0);
        check("abort_done",   64'(done_a),   64'd0);
        check("abort_sreset", 64'(sreset_a), 64'd1);
        check("abort_rdata",  rdata_a,       64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        chip_a_data = 64'h0000_A5A5_0F0F_1234;
        txn_a(1, n, sl, pl);
        check("post_abort_done_edge", 64'(n),  64'd99);
        check("post_abort_rdata",     rdata_a, EXP_P1);

        // NDATA=64, all-ones chain
        chip_b_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk); en_b = 1'b1;
        @(posedge clk); #1; en_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("n64_done_edge", 64'(n),  64'd131);
        check("n64_rdata",     rdata_b, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("n64_done_held", 64'(done_b), 64'd1);
        check("n64_sclk_idle", 64'(sclk_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
